led_code_scheduler: RTL

Status-LED controller that shares one board LED among NUM_REQ status requesters. Each granted requester is shown as a blink code: requester i produces i+1 pulses, then an inter-code gap. Arbitration is round-robin. The block sits beside the free-running heartbeat blinker and drives the LED pin mux in the fpga/src/leds area.

---
 rtl/led_code_scheduler.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/led_code_scheduler.sv
// rtl/led_code_scheduler.sv - round-robin blink-code scheduler sharing one status LED.
// Optional lamp-test override of led_out is built when LED_LAMP_TEST_EN is defined.
module led_code_scheduler #(
   parameter int          NUM_REQ   = 4,
   parameter logic [27:0] TICK_DIV  = 28'd4_000_000,
   parameter int          ON_TICKS  = 2,
   parameter int          OFF_TICKS = 3,
   parameter int          GAP_TICKS = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
`ifdef LED_LAMP_TEST_EN
   input  logic                       lamp_test,
`endif
   output logic                       led_out,
   output logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id
);

   localparam int IW  = $clog2(NUM_REQ);
   localparam int PW  = IW + 1;
   localparam int PHW = 16;

   typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_GAP} state_t;

   state_t          state, state_n;
   logic [27:0]     tick_cnt;
   logic            tick;
   logic [PHW-1:0]  phase, phase_n, phase_last;
   logic [PW-1:0]   pulse, pulse_n;
   logic [IW-1:0]   last, last_n, grant_n, winner, cand;
   logic            win_found;
   logic            led_fsm, led_fsm_n, busy_n;

   // Free-running timebase; the FSM never restarts it.
   assign tick = (tick_cnt == TICK_DIV - 28'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 28'd1;
      end
   end

   // Round-robin search starting just past the last winner.
   always_comb begin : arbiter
      winner    = '0;
      win_found = 1'b0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IW'((int'(last) + k) % NUM_REQ);
         if (!win_found && req[cand]) begin
            winner    = cand;
            win_found = 1'b1;
         end
      end
   end

   always_comb begin : phase_limit
      phase_last = '0;
      case (state)
         S_ON:    phase_last = PHW'(ON_TICKS - 1);
         S_OFF:   phase_last = PHW'(OFF_TICKS - 1);
         S_GAP:   phase_last = PHW'(GAP_TICKS - 1);
         default: phase_last = '0;
      endcase
   end

   always_comb begin : fsm_next
      state_n   = state;
      phase_n   = phase;
      pulse_n   = pulse;
      led_fsm_n = led_fsm;
      busy_n    = busy;
      grant_n   = grant_id;
      last_n    = last;
      case (state)
         S_IDLE: begin
            if (tick && win_found) begin
               state_n   = S_ON;
               phase_n   = '0;
               pulse_n   = '0;
               grant_n   = winner;
               last_n    = winner;
               led_fsm_n = 1'b1;
               busy_n    = 1'b1;
            end
         end
         S_ON: begin
            if (tick) begin
               if (phase == phase_last) begin
                  state_n   = S_OFF;
                  phase_n   = '0;
                  led_fsm_n = 1'b0;
                  pulse_n   = pulse + PW'(1);
               end else begin
                  phase_n = phase + PHW'(1);
               end
            end
         end
         S_OFF: begin
            if (tick) begin
               if (phase == phase_last) begin
                  phase_n = '0;
                  // Widened compare so code NUM_REQ does not wrap at NUM_REQ=8.
                  if (pulse == ({1'b0, grant_id} + PW'(1))) begin
                     state_n = S_GAP;
                  end else begin
                     state_n   = S_ON;
                     led_fsm_n = 1'b1;
                  end
               end else begin
                  phase_n = phase + PHW'(1);
               end
            end
         end
         S_GAP: begin
            if (tick) begin
               if (phase == phase_last) begin
                  state_n = S_IDLE;
                  phase_n = '0;
                  busy_n  = 1'b0;
               end else begin
                  phase_n = phase + PHW'(1);
               end
            end
         end
         default: begin
            state_n = S_IDLE;
            phase_n = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         phase    <= '0;
         pulse    <= '0;
         led_fsm  <= 1'b0;
         busy     <= 1'b0;
         grant_id <= '0;
         last     <= IW'(NUM_REQ - 1);
      end else begin
         state    <= state_n;
         phase    <= phase_n;
         pulse    <= pulse_n;
         led_fsm  <= led_fsm_n;
         busy     <= busy_n;
         grant_id <= grant_n;
         last     <= last_n;
      end
   end

`ifdef LED_LAMP_TEST_EN
   logic led_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         led_q <= 1'b0;
      end else begin
         led_q <= lamp_test | led_fsm_n;
      end
   end

   assign led_out = led_q;
`else
   assign led_out = led_fsm;
`endif

endmodule
